instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Fetch/issue controller for the 32-bit processor datapath. Holds a small program memory, maintains the program counter and sequences one instruction at a time into the execution unit through a valid/ready issue handshake. It then waits for completion and applies PC-relative branches reported by the execution unit. Decodes only the opcode field [31:27], which it needs for halt and jump. All arithmetic and flag logic stays in the execution unit.

Parameters:
PROG_DEPTH, 32, program memory depth in 32-bit words.
PC_W, 5, program counter width; PROG_DEPTH = 2**PC_W.
WDOG_CYCLES, 16, WAIT-state timeout in cycles; used only with SEQ_WATCHDOG_EN.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
load_en  in  1  program-memory write strobe
load_addr  in  PC_W  program-memory write address
load_data  in  32  program-memory write data
start  in  1  one-cycle pulse; begins execution at PC 0
issue_valid  out  1  issue_instr is valid for the execution unit
issue_instr  out  32  instruction word being issued
issue_ready  in  1  execution unit accepts the issued instruction
exec_done  in  1  execution unit finished the current instruction
branch_taken  in  1  branch condition true; sampled only with exec_done
pc  out  PC_W  current program counter
busy  out  1  high in FETCH, ISSUE and WAIT
halted  out  1  high in HALT
retired_count  out  16  instructions completed since last start
wdog_err  out  1  watchdog timeout, sticky

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, issue_instr=0, retired_count=0, wdog_err=0.
  - All outputs 0. Program memory contents are not reset.
- States: IDLE, FETCH, ISSUE, WAIT, HALT. State encoding is free.
- IDLE/HALT:
  - load_en writes mem[load_addr]=load_data at the clock edge.
  - load_en is ignored in every other state.
  - start -> FETCH, pc=0, retired_count=0, wdog_err=0.
  - If start and load_en occur in the same cycle, both take effect.
- FETCH: issue_instr <= mem[pc] (registered) -> ISSUE. Takes one cycle.
- ISSUE, opcode 5'b00001 (halt):
  - issue_valid stays 0; -> HALT next cycle.
  - pc holds the halt address; the halt is not counted in retired_count.
- ISSUE, any other opcode:
  - issue_valid=1 combinationally; issue_instr held stable.
  - Transfer occurs on a cycle with issue_valid && issue_ready -> WAIT.
  - issue_valid must not drop before the transfer.
- WAIT:
  - On exec_done=1 -> FETCH; retired_count increments, saturating at 16'hFFFF.
  - next pc = pc+1+issue_instr[PC_W-1:0] when opcode==5'b10110 (jump), or when branch_taken=1.
  - Otherwise next pc = pc+1.
  - All pc arithmetic is modulo PROG_DEPTH: wrap-around is silent, with no halt.
- exec_done and branch_taken are ignored outside WAIT. exec_done in the same cycle as the issue transfer is ignored.
- start while busy is ignored.
- Reset mid-operation aborts immediately to IDLE; an in-flight instruction is dropped.
- Latency:
  - start edge -> issue_valid high 2 cycles later.
  - Minimum 3 cycles per instruction (FETCH, ISSUE with ready, WAIT with done).
  - Straight-line loop throughput is 1 instruction per 3 cycles.

Optional Feature:
Macro SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs while in WAIT and clears on entering WAIT.
  - If WDOG_CYCLES cycles elapse without exec_done -> HALT, with wdog_err=1 until the next accepted start.
  - exec_done in the timeout cycle wins: normal completion, no error.
- Undefined: no counter; WAIT lasts indefinitely; wdog_err tied to 0.

Test Plan:
- Reset with start=1, issue_ready=1 held -> all outputs 0, state IDLE, no issue until after rst_n rises and a start pulse arrives.
- Load mem[0..2]={ADD 32'h1000_0000, NOP 0, HALT 32'h0800_0000}; start; ready=1; exec_done 1 cycle after each issue:
  - issue_valid first 2 cycles after start.
  - Two instructions issued; halted=1, pc=2, retired_count=2.
- mem[0]=32'h7000_0003 (branch opcode 01110), branch_taken=1 with exec_done -> next fetch at pc=4. Repeat with branch_taken=0 -> pc=1.
- mem[31]=jump 32'hB000_0001 -> pc wraps to (31+1+1) mod 32 = 1. Separately, sequential wrap 31 -> 0.
- Hold issue_ready=0 for 5 cycles -> issue_valid and issue_instr stable all 5 cycles. A load_en pulse during busy leaves the memory unchanged; start during WAIT is ignored.
- SEQ_WATCHDOG_EN, WDOG_CYCLES=16, never assert exec_done -> HALT and wdog_err=1 after 16 WAIT cycles. A following start clears wdog_err.

Source files
------------

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program memory, PC and one-at-a-time issue/wait sequencer
// Optional WAIT-state watchdog enabled by defining SEQ_WATCHDOG_EN.
module instr_sequencer #(
   parameter int PROG_DEPTH  = 32,
   parameter int PC_W        = 5,
   parameter int WDOG_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_en,
   input  logic [PC_W-1:0] load_addr,
   input  logic [31:0]     load_data,
   input  logic            start,
   output logic            issue_valid,
   output logic [31:0]     issue_instr,
   input  logic            issue_ready,
   input  logic            exec_done,
   input  logic            branch_taken,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted,
   output logic [15:0]     retired_count,
   output logic            wdog_err
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

   localparam logic [4:0] OP_HALT = 5'b00001;
   localparam logic [4:0] OP_JUMP = 5'b10110;

   logic [31:0]     mem [PROG_DEPTH];

   logic [2:0]      state_q,   state_d;
   logic [PC_W-1:0] pc_q,      pc_d;
   logic [31:0]     instr_q,   instr_d;
   logic [15:0]     retired_q, retired_d;

   logic            is_halt;
   logic            is_jump;
   logic            can_load;
   logic [PC_W-1:0] pc_seq;
   logic [PC_W-1:0] pc_rel;

   assign is_halt  = (instr_q[31:27] == OP_HALT);
   assign is_jump  = (instr_q[31:27] == OP_JUMP);
   assign can_load = (state_q == ST_IDLE) || (state_q == ST_HALT);
   // PC_W-bit arithmetic gives the modulo-PROG_DEPTH wrap for free
   assign pc_seq   = pc_q + PC_W'(1);
   assign pc_rel   = pc_q + PC_W'(1) + instr_q[PC_W-1:0];

`ifdef SEQ_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

   logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
   logic              wdog_err_q, wdog_err_d;
   logic              wdog_expire;

   assign wdog_cnt_d  = (state_q == ST_WAIT) ? wdog_cnt_q + WDOG_W'(1) : '0;
   assign wdog_expire = (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
   assign wdog_err    = wdog_err_q;
`else
   // never true; keeps the watchdog parameter referenced in this build
   assign wdog_err = (WDOG_CYCLES < 0);
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
`ifdef SEQ_WATCHDOG_EN
      wdog_err_d = wdog_err_q;
`endif
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d   = ST_FETCH;
               pc_d      = '0;
               retired_d = '0;
`ifdef SEQ_WATCHDOG_EN
               wdog_err_d = 1'b0;
`endif
            end
         end
         ST_FETCH: begin
            instr_d = mem[pc_q];
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (is_halt) begin
               state_d = ST_HALT;
            end else if (issue_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (exec_done) begin
               state_d = ST_FETCH;
               pc_d    = (is_jump || branch_taken) ? pc_rel : pc_seq;
               if (retired_q != 16'hFFFF) begin
                  retired_d = retired_q + 16'd1;
               end
            end
`ifdef SEQ_WATCHDOG_EN
            else if (wdog_expire) begin
               state_d    = ST_HALT;
               wdog_err_d = 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         instr_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

`ifdef SEQ_WATCHDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
         wdog_err_q <= wdog_err_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (load_en && can_load) begin
         mem[load_addr] <= load_data;
      end
   end

   assign issue_valid   = (state_q == ST_ISSUE) && !is_halt;
   assign issue_instr   = instr_q;
   assign pc            = pc_q;
   assign busy          = (state_q == ST_FETCH) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign halted        = (state_q == ST_HALT);
   assign retired_count = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed vector table plus hand sequences for instr_sequencer
module tb_instr_sequencer;

   localparam int PC_W = 5;
   localparam logic [31:0] HALT_W = 32'h0800_0000;

   logic            clk;
   logic            rst_n;
   logic            load_en;
   logic [PC_W-1:0] load_addr;
   logic [31:0]     load_data;
   logic            start;
   logic            issue_valid;
   logic [31:0]     issue_instr;
   logic            issue_ready;
   logic            exec_done;
   logic            branch_taken;
   logic [PC_W-1:0] pc;
   logic            busy;
   logic            halted;
   logic [15:0]     retired_count;
   logic            wdog_err;

   int total = 0;
   int bad   = 0;

   instr_sequencer #(.PROG_DEPTH(32), .PC_W(PC_W), .WDOG_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .issue_valid(issue_valid),
      .issue_instr(issue_instr), .issue_ready(issue_ready), .exec_done(exec_done),
      .branch_taken(branch_taken), .pc(pc), .busy(busy), .halted(halted),
      .retired_count(retired_count), .wdog_err(wdog_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        ready;
      logic        done;
      logic        br;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [4:0]  exp_pc;
      logic        exp_busy;
      logic        exp_halted;
      logic [15:0] exp_ret;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [4:0] addr, input logic [31:0] data);
      load_en   = 1'b1;
      load_addr = addr;
      load_data = data;
      step();
      load_en   = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      check("start busy", 32'(busy), 32'd1);
      check("start pc", 32'(pc), 32'd0);
      check("start retired", 32'(retired_count), 32'd0);
   endtask

   task automatic exec_one(input logic br, input logic [31:0] exp_instr, input logic [4:0] exp_pc);
      step();
      check("exec issue_valid", 32'(issue_valid), 32'd1);
      check("exec issue_instr", issue_instr, exp_instr);
      issue_ready = 1'b1;
      step();
      issue_ready  = 1'b0;
      exec_done    = 1'b1;
      branch_taken = br;
      step();
      exec_done    = 1'b0;
      branch_taken = 1'b0;
      check("exec next pc", 32'(pc), 32'(exp_pc));
   endtask

   task automatic expect_halt(input logic [4:0] exp_pc, input logic [15:0] exp_ret);
      step();
      check("halt issue_valid", 32'(issue_valid), 32'd0);
      step();
      check("halt halted", 32'(halted), 32'd1);
      check("halt busy", 32'(busy), 32'd0);
      check("halt pc", 32'(pc), 32'(exp_pc));
      check("halt retired", 32'(retired_count), 32'(exp_ret));
   endtask

   initial begin
      //        st    rd    dn    br    valid instr          pc    busy  halt  ret
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         5'd0, 1'b1, 1'b0, 16'd0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 5'd0, 1'b1, 1'b0, 16'd0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 5'd0, 1'b1, 1'b0, 16'd0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0000, 5'd1, 1'b1, 1'b0, 16'd1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         5'd1, 1'b1, 1'b0, 16'd1};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         5'd1, 1'b1, 1'b0, 16'd1};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         5'd2, 1'b1, 1'b0, 16'd2};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HALT_W,        5'd2, 1'b1, 1'b0, 16'd2};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, HALT_W,        5'd2, 1'b0, 1'b1, 16'd2};
      tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, HALT_W,        5'd2, 1'b0, 1'b1, 16'd2};

      rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b1; issue_ready = 1'b1; exec_done = 1'b0; branch_taken = 1'b0;
      repeat (3) step();
      check("rst issue_valid", 32'(issue_valid), 32'd0);
      check("rst issue_instr", issue_instr, 32'd0);
      check("rst pc", 32'(pc), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst halted", 32'(halted), 32'd0);
      check("rst retired", 32'(retired_count), 32'd0);
      check("rst wdog_err", 32'(wdog_err), 32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) step();
      check("post-rst idle busy", 32'(busy), 32'd0);
      check("post-rst idle valid", 32'(issue_valid), 32'd0);
      issue_ready = 1'b0;

      for (int a = 0; a < 32; a++) load(5'(a), HALT_W);
      load(5'd0, 32'h1000_0000);
      load(5'd1, 32'h0000_0000);
      load(5'd2, HALT_W);

      for (int i = 0; i < 10; i++) begin
         start        = tbl[i].start;
         issue_ready  = tbl[i].ready;
         exec_done    = tbl[i].done;
         branch_taken = tbl[i].br;
         step();
         check($sformatf("v%0d valid", i),  32'(issue_valid),   32'(tbl[i].exp_valid));
         check($sformatf("v%0d instr", i),  issue_instr,        tbl[i].exp_instr);
         check($sformatf("v%0d pc", i),     32'(pc),            32'(tbl[i].exp_pc));
         check($sformatf("v%0d busy", i),   32'(busy),          32'(tbl[i].exp_busy));
         check($sformatf("v%0d halted", i), 32'(halted),        32'(tbl[i].exp_halted));
         check($sformatf("v%0d ret", i),    32'(retired_count), 32'(tbl[i].exp_ret));
      end
      start = 1'b0; issue_ready = 1'b0; exec_done = 1'b0; branch_taken = 1'b0;

      load(5'd0, 32'h7000_0003);
      load(5'd1, HALT_W);
      do_start();
      exec_one(1'b1, 32'h7000_0003, 5'd4);
      expect_halt(5'd4, 16'd1);
      do_start();
      exec_one(1'b0, 32'h7000_0003, 5'd1);
      expect_halt(5'd1, 16'd1);

      load(5'd0, 32'hB000_0002);
      do_start();
      exec_one(1'b0, 32'hB000_0002, 5'd3);
      expect_halt(5'd3, 16'd1);

      load(5'd0, 32'h7000_001E);
      load(5'd31, 32'hB000_0001);
      do_start();
      exec_one(1'b1, 32'h7000_001E, 5'd31);
      exec_one(1'b0, 32'hB000_0001, 5'd1);
      expect_halt(5'd1, 16'd2);

      load(5'd31, 32'h1000_0000);
      do_start();
      exec_one(1'b1, 32'h7000_001E, 5'd31);
      exec_one(1'b0, 32'h1000_0000, 5'd0);
      exec_one(1'b0, 32'h7000_001E, 5'd1);
      expect_halt(5'd1, 16'd3);

      load(5'd0, 32'h1234_5678);
      do_start();
      step();
      check("stall enter valid", 32'(issue_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         load_en = 1'b1; load_addr = 5'd1; load_data = 32'h0;
         step();
         check($sformatf("stall%0d valid", k), 32'(issue_valid), 32'd1);
         check($sformatf("stall%0d instr", k), issue_instr, 32'h1234_5678);
      end
      load_en = 1'b0;
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      check("wait start busy", 32'(busy), 32'd1);
      check("wait start valid", 32'(issue_valid), 32'd0);
      exec_done = 1'b1;
      step();
      exec_done = 1'b0;
      check("wait done pc", 32'(pc), 32'd1);
      check("wait done retired", 32'(retired_count), 32'd1);
      expect_halt(5'd1, 16'd1);

      do_start();
      step();
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
`ifdef SEQ_WATCHDOG_EN
      for (int k = 0; k < 15; k++) step();
      check("wdog pre busy", 32'(busy), 32'd1);
      check("wdog pre err", 32'(wdog_err), 32'd0);
      step();
      check("wdog halted", 32'(halted), 32'd1);
      check("wdog err", 32'(wdog_err), 32'd1);
      check("wdog pc", 32'(pc), 32'd0);
      do_start();
      check("wdog err cleared", 32'(wdog_err), 32'd0);
      step();
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      for (int k = 0; k < 15; k++) step();
      exec_done = 1'b1;
      step();
      exec_done = 1'b0;
      check("wdog race busy", 32'(busy), 32'd1);
      check("wdog race err", 32'(wdog_err), 32'd0);
      check("wdog race pc", 32'(pc), 32'd1);
      expect_halt(5'd1, 16'd1);
`else
      for (int k = 0; k < 20; k++) step();
      check("no-wdog still busy", 32'(busy), 32'd1);
      check("no-wdog err", 32'(wdog_err), 32'd0);
      exec_done = 1'b1;
      step();
      exec_done = 1'b0;
      check("no-wdog done pc", 32'(pc), 32'd1);
      expect_halt(5'd1, 16'd1);
`endif

      do_start();
      step();
      rst_n = 1'b0;
      #1;
      check("async rst busy", 32'(busy), 32'd0);
      check("async rst valid", 32'(issue_valid), 32'd0);
      check("async rst instr", issue_instr, 32'd0);
      check("async rst retired", 32'(retired_count), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("after rst idle", 32'(busy) | 32'(halted), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
